writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Write-side front end of the integer register file: merges single-cycle pipeline results and long-latency completions (loads, multi-cycle mul/div) onto the register file's single write port. Long-latency results are buffered in a small FIFO whenever the pipeline owns the port. A per-register scoreboard stalls issue on RAW/WAW hazards against in-flight long-latency destinations. Sits between the execute/memory stages and the register file, driving its `WE3`/`AD3`/`WD3` port.

## Interface
- `XLEN`, 32, data width
- `DEPTH`, 4, long-latency FIFO entries (power of two, ≥2)

- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — synchronous reset, active-high
- `pipe_we_i` in 1 — pipeline result valid this cycle (cannot be back-pressured)
- `pipe_rd_i` in 5 — pipeline destination
- `pipe_wd_i` in XLEN — pipeline data
- `ll_valid_i` in 1 — long-latency result valid
- `ll_ready_o` out 1 — FIFO can accept
- `ll_rd_i` in 5 — long-latency destination
- `ll_wd_i` in XLEN — long-latency data
- `iss_valid_i` in 1 — instruction at issue
- `iss_ll_i` in 1 — issuing instruction is long-latency
- `iss_rs1_i`, `iss_rs2_i`, `iss_rd_i` in 5 each — issue operands/destination
- `iss_stall_o` out 1 — hold issue this cycle
- `rf_we_o` out 1 — to register file `WE3`
- `rf_ad_o` out 5 — to `AD3`
- `rf_wd_o` out XLEN — to `WD3`
- `busy_o` out 32 — scoreboard bits, debug/visibility

## Operation
- Port owner per cycle, priority order: (1) pipeline if `pipe_we_i && pipe_rd_i!=0`; (2) FIFO head if non-empty; (3) bypass of `ll` input if FIFO empty and handshake fires; else idle (`rf_we_o=0`, `rf_ad_o=0`, `rf_wd_o=0`).
- Pipeline write with `pipe_rd_i==0` is dropped; port counts as free.
- `ll_ready_o = !full` (registered occupancy). Handshake = `ll_valid_i && ll_ready_o`. Handshake result is pushed unless bypassed in the same cycle; pop when FIFO head owns port. Push and pop in the same cycle keep the count.
- Long-latency result with `ll_rd_i==0`: accepted and discarded, never written.
- FIFO preserves completion order.
- Scoreboard: `busy[iss_rd_i]` set at the edge when `iss_valid_i && iss_ll_i && !iss_stall_o && iss_rd_i!=0`. `busy[rf_ad_o]` cleared at the edge when a long-latency (FIFO or bypass) write owns the port. `busy[0]` is always 0.
- `iss_stall_o` (combinational from registered busy/in-flight) = `iss_valid_i && (busy[rs1] || busy[rs2] || busy[rd] || (iss_ll_i && inflight==DEPTH))`. Index 0 is never busy.
- A clear does not bypass into the same-cycle stall. Stall drops the cycle after the write.
- `inflight` counter: +1 on long-latency issue, −1 on long-latency write or discard (rd 0). This bounds FIFO occupancy to DEPTH, so the pipeline never overflows it.
- WAW ordering is guaranteed by the stall on `busy[rd]`. The pipeline never writes a register with a pending long-latency write.

## Timing
- Port outputs are combinational from current inputs and FIFO head. The register file captures them on the falling edge of the same cycle, giving 0-cycle writeback latency.
- FIFO path latency: push at edge N, earliest write in cycle N+1.
- Reset (sync, edge with `rst=1`):
  - FIFO empty, `inflight=0`, `busy_o=0`.
  - While `rst` is high: `rf_we_o=0`, `ll_ready_o=0`, `iss_stall_o=0`.
  - Entries in flight at reset are lost. The producing units are reset in the same cycle.
- Full: `ll_ready_o=0`; the producer holds data stable until the handshake.
- Empty + pipeline idle + `ll` valid: bypass, no FIFO occupancy.

## Structure
- Package `wb_pkg`: `XLEN`, `REG_AW=5`, `typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] wd;} wb_entry_t`.
- Sub-module `sync_fifo` (parameterised DEPTH, `wb_entry_t` payload, push/pop/full/empty/count). The arbiter, scoreboard and stall logic live in `writeback_arbiter`.

## Test plan
- Long-latency issue to rd=5, then a dependent issue reading rs1=5 → `iss_stall_o=1` until the cycle after the `ll` write of 0xDEADBEEF to x5; then `busy_o[5]=0`.
- Pipeline writes x3 every cycle for 6 cycles while `ll` presents x7=0x11, x8=0x22 → both queued, written in order (x7 then x8) on the first two idle cycles.
- `ll` floods 5 results with the pipeline saturating the port → `ll_ready_o` drops after 4 pushes; no loss, order preserved on drain.
- Pipeline write to x0 concurrent with non-empty FIFO → FIFO head written that cycle; x0 never written.
- Empty FIFO, pipeline idle, `ll` x9=0x1234 → `rf_we_o=1`, `rf_ad_o=9` the same cycle, count stays 0.
- `rst` asserted with 3 queued entries and busy bits set → next cycle `busy_o=0`, `ll_ready_o=1`, `rf_we_o=0`.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the register-file writeback front end
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;

  // x0 is hard-wired, so it can never hold a pending write
  function automatic logic reg_busy(input logic [31:0] busy, input logic [REG_AW-1:0] idx);
    return (idx != '0) && busy[idx];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered-occupancy FIFO of writeback entries
module sync_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_entry_t     push_data,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and long-latency results onto the register file write port
module writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_i,
  input  logic [XLEN-1:0] pipe_wd_i,
  input  logic            ll_valid_i,
  output logic            ll_ready_o,
  input  logic [4:0]      ll_rd_i,
  input  logic [XLEN-1:0] ll_wd_i,
  input  logic            iss_valid_i,
  input  logic            iss_ll_i,
  input  logic [4:0]      iss_rs1_i,
  input  logic [4:0]      iss_rs2_i,
  input  logic [4:0]      iss_rd_i,
  output logic            iss_stall_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_ad_o,
  output logic [XLEN-1:0] rf_wd_o,
  output logic [31:0]     busy_o
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   busy_q;
  logic [31:0]   busy_d;
  logic [CW-1:0] inflight_q;

  wb_entry_t     ll_entry;
  wb_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_push;
  logic          fifo_pop;

  logic          pipe_own;
  logic          fifo_own;
  logic          ll_hs;
  logic          bypass;
  logic          ll_discard;
  logic          ll_write;
  logic          iss_fire;

  assign ll_entry = '{rd: ll_rd_i, wd: ll_wd_i};

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ll_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ll_ready_o = !rst && !fifo_full;
  assign ll_hs      = ll_valid_i && ll_ready_o;
  assign pipe_own   = pipe_we_i && (pipe_rd_i != '0);
  assign fifo_own   = !rst && !pipe_own && !fifo_empty;
  // A result only skips the FIFO when nothing is queued ahead of it
  assign bypass     = ll_hs && !pipe_own && (fifo_count == '0);
  assign ll_discard = ll_hs && (ll_rd_i == '0);
  assign ll_write   = fifo_own || (bypass && !ll_discard);
  assign fifo_push  = ll_hs && !bypass && !ll_discard;
  assign fifo_pop   = fifo_own;

  always_comb begin
    rf_we_o = 1'b0;
    rf_ad_o = '0;
    rf_wd_o = '0;
    if (!rst) begin
      if (pipe_own) begin
        rf_we_o = 1'b1;
        rf_ad_o = pipe_rd_i;
        rf_wd_o = pipe_wd_i;
      end else if (fifo_own) begin
        rf_we_o = 1'b1;
        rf_ad_o = head.rd;
        rf_wd_o = head.wd;
      end else if (bypass && !ll_discard) begin
        rf_we_o = 1'b1;
        rf_ad_o = ll_rd_i;
        rf_wd_o = ll_wd_i;
      end
    end
  end

  // Stall uses only registered state; a clear this cycle is seen next cycle
  assign iss_stall_o = !rst && iss_valid_i &&
                       (reg_busy(busy_q, iss_rs1_i) || reg_busy(busy_q, iss_rs2_i) ||
                        reg_busy(busy_q, iss_rd_i)  ||
                        (iss_ll_i && (inflight_q == CW'(DEPTH))));
  assign iss_fire    = iss_valid_i && iss_ll_i && !iss_stall_o;

  always_comb begin
    busy_d = busy_q;
    if (ll_write) busy_d[rf_ad_o] = 1'b0;
    if (iss_fire && (iss_rd_i != '0)) busy_d[iss_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_q + CW'(iss_fire) - CW'(ll_write) - CW'(ll_discard);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized checks of writeback_arbiter against a queue model
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_wd;
  logic        iss_valid;
  logic        iss_ll;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        rf_we;
  logic [4:0]  rf_ad;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we_i   (pipe_we),
    .pipe_rd_i   (pipe_rd),
    .pipe_wd_i   (pipe_wd),
    .ll_valid_i  (ll_valid),
    .ll_ready_o  (ll_ready),
    .ll_rd_i     (ll_rd),
    .ll_wd_i     (ll_wd),
    .iss_valid_i (iss_valid),
    .iss_ll_i    (iss_ll),
    .iss_rs1_i   (iss_rs1),
    .iss_rs2_i   (iss_rs2),
    .iss_rd_i    (iss_rd),
    .iss_stall_o (iss_stall),
    .rf_we_o     (rf_we),
    .rf_ad_o     (rf_ad),
    .rf_wd_o     (rf_wd),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  int          tests  = 0;
  int          failed = 0;
  ent_t        m_q[$];
  logic [31:0] m_busy;
  int          m_inflight;
  bit          m_hs;
  bit          m_issued;
  logic [4:0]  issued[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bz(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  task automatic model_reset();
    m_q.delete();
    issued.delete();
    m_busy     = '0;
    m_inflight = 0;
    m_hs       = 0;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    ll_valid = 0; ll_rd = 0; ll_wd = 0;
    iss_valid = 0; iss_ll = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // One cycle: predict the port from the spec rules, compare, clock, then advance the model
  task automatic step();
    bit rdy, pown, hs, wr_ll, byp, disc, stall, pop;
    logic we;
    logic [4:0] ad;
    logic [31:0] wd;
    ent_t e;
    #1;
    rdy  = !rst && (m_q.size() < DEPTH);
    pown = pipe_we && (pipe_rd != 0);
    hs   = ll_valid && rdy;
    we = 0; ad = 0; wd = 0; wr_ll = 0; byp = 0; pop = 0;
    if (!rst) begin
      if (pown) begin
        we = 1; ad = pipe_rd; wd = pipe_wd;
      end else if (m_q.size() > 0) begin
        we = 1; ad = m_q[0].rd; wd = m_q[0].wd; wr_ll = 1; pop = 1;
      end else if (hs) begin
        byp = 1;
        if (ll_rd != 0) begin
          we = 1; ad = ll_rd; wd = ll_wd; wr_ll = 1;
        end
      end
    end
    disc  = hs && (ll_rd == 0);
    stall = !rst && iss_valid &&
            (bz(iss_rs1) || bz(iss_rs2) || bz(iss_rd) || (iss_ll && m_inflight == DEPTH));
    chk("rf_we", 64'(rf_we), 64'(we));
    chk("rf_ad", 64'(rf_ad), 64'(ad));
    chk("rf_wd", 64'(rf_wd), 64'(wd));
    chk("ll_ready", 64'(ll_ready), 64'(rdy));
    chk("iss_stall", 64'(iss_stall), 64'(stall));
    chk("busy", 64'(busy), 64'(m_busy));
    e.rd = ll_rd;
    e.wd = ll_wd;
    m_issued = !rst && iss_valid && iss_ll && !stall;
    @(posedge clk);
    if (rst) begin
      model_reset();
      m_issued = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (hs && !byp && (e.rd != 0)) m_q.push_back(e);
      if (wr_ll) begin
        m_busy[ad] = 1'b0;
        m_inflight--;
      end
      if (disc) m_inflight--;
      if (m_issued) begin
        m_inflight++;
        if (iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
      m_hs = hs;
    end
    #1;
  endtask

  initial begin
    int k;
    int exp_rd;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    iss_valid = 1; iss_rs1 = 1;
    step();
    idle();
    rst = 0;

    // RAW stall on an outstanding long-latency destination
    iss_valid = 1; iss_ll = 1; iss_rd = 5;
    step();
    iss_ll = 0; iss_rs1 = 5; iss_rd = 6;
    settle();
    chk("raw_stall", 64'(iss_stall), 64'd1);
    step();
    step();
    ll_valid = 1; ll_rd = 5; ll_wd = 32'hDEADBEEF;
    settle();
    chk("raw_write_ad", 64'(rf_ad), 64'd5);
    chk("raw_write_wd", 64'(rf_wd), 64'hDEADBEEF);
    chk("raw_stall_same_cycle", 64'(iss_stall), 64'd1);
    step();
    ll_valid = 0;
    settle();
    chk("raw_stall_released", 64'(iss_stall), 64'd0);
    chk("raw_busy5", 64'(busy[5]), 64'd0);
    step();
    idle();

    // Pipeline owns the port; queued results drain in order afterwards
    pipe_we = 1; pipe_rd = 3;
    for (int i = 0; i < 6; i++) begin
      pipe_wd  = $urandom;
      ll_valid = (i < 2);
      ll_rd    = (i == 0) ? 5'd7 : 5'd8;
      ll_wd    = (i == 0) ? 32'h11 : 32'h22;
      step();
    end
    idle();
    settle();
    chk("queue_first", 64'({rf_we, rf_ad, rf_wd}), 64'({1'b1, 5'd7, 32'h11}));
    step();
    chk("queue_second", 64'({rf_we, rf_ad, rf_wd}), 64'({1'b1, 5'd8, 32'h22}));
    step();
    step();

    // Flood: FIFO fills, producer holds, then drains in order (x0 pipeline write yields)
    k = 0;
    exp_rd = 10;
    for (int c = 0; c < 30; c++) begin
      pipe_we = (c <= 8);
      pipe_rd = (c == 8) ? 5'd0 : 5'd3;
      pipe_wd = $urandom;
      ll_valid = (k < 5);
      ll_rd    = 5'(10 + k);
      ll_wd    = 32'(100 + k);
      settle();
      if (c == 4) chk("flood_full", 64'(ll_ready), 64'd0);
      if (c == 8) chk("x0_yields", 64'({rf_we, rf_ad}), 64'({1'b1, 5'd10}));
      if (c >= 8 && rf_we) begin
        chk("drain_order", 64'({rf_ad, rf_wd}), 64'({5'(exp_rd), 32'(100 + exp_rd - 10)}));
        exp_rd++;
      end
      step();
      if (m_hs) k++;
    end
    chk("flood_drained", 64'(exp_rd), 64'd15);
    idle();

    // Bypass: empty FIFO and idle pipeline write the result the same cycle
    ll_valid = 1; ll_rd = 9; ll_wd = 32'h1234;
    settle();
    chk("bypass", 64'({rf_we, rf_ad, rf_wd}), 64'({1'b1, 5'd9, 32'h1234}));
    step();
    ll_valid = 0;
    settle();
    chk("bypass_no_occupancy", 64'(ll_ready), 64'd1);
    step();
    rst = 1;
    step();
    rst = 0;

    // Reset with queued entries and busy bits
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1; iss_ll = 1; iss_rd = 5'(20 + i);
      step();
    end
    idle();
    pipe_we = 1; pipe_rd = 3;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1; ll_rd = 5'(20 + i); ll_wd = $urandom;
      step();
    end
    ll_valid = 0;
    settle();
    chk("pre_reset_busy", 64'(busy[22:20]), 64'd7);
    rst = 1;
    step();
    rst = 0;
    idle();
    settle();
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_ready", 64'(ll_ready), 64'd1);
    chk("post_reset_we", 64'(rf_we), 64'd0);
    step();

    // Randomized traffic; completions follow issue order and honour the hold rule
    for (int c = 0; c < 500; c++) begin
      if (!(ll_valid && !m_hs)) begin
        if (issued.size() > 0 && $urandom_range(0, 2) == 0) begin
          ll_valid = 1;
          ll_rd    = issued.pop_front();
          ll_wd    = $urandom;
        end else begin
          ll_valid = 0;
        end
      end
      pipe_we   = $urandom_range(0, 1);
      pipe_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_wd   = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_ll    = $urandom_range(0, 1);
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 9));
      step();
      if (m_issued) issued.push_back(iss_rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
